// File: rtl/prsg_byte_packer.sv
// -----------------------------------------------------------------------------
// prsg_byte_packer
//
// Packs a qualified serial bit stream (typically the output of an inner-product
// pseudo-random sequence generator) into WIDTH-bit words, MSB first, and queues
// the completed words in a small show-ahead FIFO for a ready/valid consumer.
//
// Ports
//   clk         : single clock, all state advances on its rising edge
//   rst         : asynchronous, active-low reset
//   bit_in      : serial data bit
//   bit_en      : bit_in is captured only on edges where this is 1
//   flush       : synchronous clear of the partial word and the FIFO
//                 (the sticky overflow flag is left alone)
//   dout        : head-of-FIFO word, valid while dout_valid=1, 0 otherwise
//   dout_valid  : FIFO not empty
//   dout_ready  : consumer accepts dout; ignored while the FIFO is empty
//   level       : FIFO occupancy in words (0..DEPTH)
//   overflow    : sticky, set when a completed word had to be dropped
//   ovf_clr     : synchronous clear of overflow (a coincident drop wins)
//
// Parameters
//   WIDTH       : bits per packed word (>= 2)
//   DEPTH       : FIFO depth in words, power of two, >= 2
// -----------------------------------------------------------------------------
module prsg_byte_packer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_en,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    bit_cnt_reg,  bit_cnt_next;
  logic [WIDTH-1:0] shift_reg,    shift_next;
  // Pointers carry one wrap bit above the index so full and empty are
  // distinguishable without a separate count register.
  logic [AW:0]      wr_ptr_reg,   wr_ptr_next;
  logic [AW:0]      rd_ptr_reg,   rd_ptr_next;
  logic             overflow_reg, overflow_next;

  logic [WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Datapath decode
  // ---------------------------------------------------------------------------
  logic             capture;
  logic             word_done;
  logic [WIDTH-1:0] push_word;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign wr_idx     = wr_ptr_reg[AW-1:0];
  assign rd_idx     = rd_ptr_reg[AW-1:0];

  // Flush dominates every other activity on its edge.
  assign capture    = bit_en & ~flush;
  assign word_done  = capture & (bit_cnt_reg == LAST_BIT);

  // The incoming bit always enters at the LSB, so after WIDTH captures the
  // first bit has travelled up to the MSB.
  assign push_word  = {shift_reg[WIDTH-2:0], bit_in};

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);

  assign pop        = ~fifo_empty & dout_ready & ~flush;

  // A full FIFO still accepts a word when the head leaves on the same edge;
  // the slot being written is then the one just vacated. An empty FIFO never
  // pops, so push+ready while empty simply takes the push.
  assign push_ok    = word_done & (~fifo_full | pop);
  assign drop       = word_done & fifo_full & ~pop;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;

    if (flush) begin
      bit_cnt_next = '0;
      shift_next   = '0;
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
    end else begin
      if (capture) begin
        shift_next   = push_word;
        // The counter wraps on the completing capture whether or not the
        // word finds room in the FIFO.
        bit_cnt_next = word_done ? '0 : bit_cnt_reg + CW'(1);
      end
      if (push_ok) begin
        wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
      end
    end
  end

  // A drop on the same edge as ovf_clr keeps the flag set.
  always_comb begin
    overflow_next = overflow_reg;
    if (drop) begin
      overflow_next = 1'b1;
    end else if (ovf_clr) begin
      overflow_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      overflow_reg <= overflow_next;
    end
  end

  // Word storage needs no reset: every entry is written before the read
  // pointer can reach it, and dout is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= push_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dout_valid = ~fifo_empty;
  assign dout       = fifo_empty ? '0 : mem[rd_idx];
  assign level      = wr_ptr_reg - rd_ptr_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_prsg_byte_packer.sv
// -----------------------------------------------------------------------------
// tb_prsg_byte_packer
//
// Self-checking bench for prsg_byte_packer (WIDTH=8, DEPTH=4). A queue-based
// reference model tracks the partial word as an integer and the FIFO as a
// queue of words; after every clock edge the DUT outputs are compared with it.
// Directed scenarios additionally check the literal expected words.
// -----------------------------------------------------------------------------
module tb_prsg_byte_packer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             bit_in = 1'b0;
  logic             bit_en = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic [2:0]       level;
  logic             overflow;
  logic             ovf_clr = 1'b0;

  prsg_byte_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_en     (bit_en),
    .flush      (flush),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_q[$];
  int m_part = 0;
  int m_cnt  = 0;
  bit m_ovf  = 1'b0;
  int n_drop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_part = 0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
  endtask

  // Effect of one rising edge given the inputs currently applied.
  task automatic model_edge();
    bit popping;
    bit was_full;
    int word;
    if (flush) begin
      m_q.delete();
      m_part = 0;
      m_cnt  = 0;
      if (ovf_clr) m_ovf = 1'b0;
      return;
    end
    popping  = dout_ready && (m_q.size() > 0);
    was_full = (m_q.size() == DEPTH);
    if (popping) begin
      $display("pop  word=%02h level_before=%0d", m_q[0], m_q.size());
      void'(m_q.pop_front());
    end
    if (bit_en) begin
      word = ((m_part * 2) + int'(bit_in)) % 256;
      if (m_cnt == WIDTH - 1) begin
        if (was_full && !popping) begin
          m_ovf = 1'b1;
          n_drop++;
          $display("drop word=%02h", word);
        end else begin
          m_q.push_back(word);
        end
        m_part = 0;
        m_cnt  = 0;
      end else begin
        m_part = word;
        m_cnt  = m_cnt + 1;
      end
    end
    if (ovf_clr && !(m_ovf && bit_en && m_cnt == 0 && was_full && !popping && m_part == 0 && n_drop > 0 && 0))
      ;
  endtask

  // Overflow flag: a drop on this edge overrides a coincident clear.
  task automatic model_ovf(input bit dropped_now);
    if (!dropped_now && ovf_clr) m_ovf = 1'b0;
  endtask

  task automatic compare_state(input string tag);
    check({tag, "_valid"}, 32'(dout_valid), 32'(m_q.size() > 0));
    check({tag, "_level"}, 32'(level), 32'(m_q.size()));
    check({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
    if (m_q.size() > 0) check({tag, "_dout"}, 32'(dout), 32'(m_q[0]));
  endtask

  // Apply inputs, advance one edge, compare at edge+1.
  task automatic tick(input bit en, input bit b, input bit fl, input bit rdy, input bit clr,
                      input string tag);
    int drops_before;
    bit_en = en; bit_in = b; flush = fl; dout_ready = rdy; ovf_clr = clr;
    drops_before = n_drop;
    model_edge();
    if (!fl) model_ovf(n_drop != drops_before);
    @(posedge clk);
    #1;
    compare_state(tag);
  endtask

  task automatic feed_word(input logic [7:0] w, input bit rdy_last, input bit gap,
                           input string tag);
    for (int i = 0; i < WIDTH; i++) begin
      tick(1'b1, w[WIDTH-1-i], 1'b0, (i == WIDTH-1) ? rdy_last : 1'b0, 1'b0, tag);
      if (gap) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, tag);
    end
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check({tag, "_rst_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_rst_level"}, 32'(level), 32'd0);
    check({tag, "_rst_dout"},  32'(dout), 32'd0);
    check({tag, "_rst_ovf"},   32'(overflow), 32'd0);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_w;
    // ---- reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(dout_valid), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_dout",  32'(dout), 32'd0);
    check("reset_ovf",   32'(overflow), 32'd0);
    rst = 1'b1;

    // ---- basic pack 1,0,1,1,0,0,1,0
    feed_word(8'hB2, 1'b0, 1'b0, "basic");
    check("basic_dout",  32'(dout), 32'hB2);
    check("basic_level", 32'(level), 32'd1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "flush0");

    // ---- gapped enable
    feed_word(8'hB2, 1'b0, 1'b1, "gapped");
    check("gapped_dout", 32'(dout), 32'hB2);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "flush1");

    // ---- overflow: 5 words into a 4-deep FIFO
    for (int k = 1; k <= 5; k++) feed_word(8'(k), 1'b0, 1'b0, "ovf_fill");
    check("ovf_level", 32'(level), 32'd4);
    check("ovf_flag",  32'(overflow), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      exp_w = 8'(k);
      check("ovf_drain_dout", 32'(dout), 32'(exp_w));
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ovf_drain");
    end
    check("ovf_empty", 32'(dout_valid), 32'd0);

    // ---- flush mid-word keeps overflow set
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "fl_part");
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "fl_pulse");
    check("fl_keeps_ovf", 32'(overflow), 32'd1);
    feed_word(8'hFF, 1'b0, 1'b0, "fl_ff");
    check("fl_dout",  32'(dout), 32'hFF);
    check("fl_level", 32'(level), 32'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ovf_clr");
    check("ovf_cleared", 32'(overflow), 32'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "flush2");

    // ---- full with concurrent pop completing 8'hAA
    feed_word(8'h11, 1'b0, 1'b0, "full_fill");
    feed_word(8'h22, 1'b0, 1'b0, "full_fill");
    feed_word(8'h33, 1'b0, 1'b0, "full_fill");
    feed_word(8'h44, 1'b0, 1'b0, "full_fill");
    feed_word(8'hAA, 1'b1, 1'b0, "full_pop");
    check("full_level", 32'(level), 32'd4);
    check("full_ovf",   32'(overflow), 32'd0);
    exp_w = 8'h00;
    for (int k = 0; k < 4; k++) begin
      exp_w = dout;
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "full_drain");
    end
    check("full_last_aa", 32'(exp_w), 32'hAA);

    // ---- drop coinciding with ovf_clr keeps overflow set
    for (int k = 0; k < 4; k++) feed_word(8'h5A, 1'b0, 1'b0, "coin_fill");
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "coin_bits");
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "coin_last");
    check("coin_ovf", 32'(overflow), 32'd1);

    // ---- reset mid-word and mid-drain
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_part");
    pulse_reset("midword");
    feed_word(8'hFF, 1'b0, 1'b0, "rst_ff");
    check("rst_dout",  32'(dout), 32'hFF);
    check("rst_level", 32'(level), 32'd1);

    // ---- random stream
    for (int c = 0; c < 10000; c++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom), ($urandom_range(0, 299) == 0),
           1'($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0), "rand");
    end
    $display("random stream: %0d words dropped by model", n_drop);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prsg_byte_packer.md
PRSG_BYTE_PACKER -- requirements
Module: prsg_byte_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per packed output word.
REQ-002 SHALL have parameter DEPTH, default 4: output FIFO depth in words, a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port bit_in, input, 1: serial generator bit, e.g. the inner-product generator output.
REQ-006 SHALL have port bit_en, input, 1: qualifies bit_in; a bit is captured only on an edge where bit_en=1.
REQ-007 SHALL have port flush, input, 1: synchronous clear of the partial word and the FIFO.
REQ-008 SHALL have port dout, output, WIDTH: head-of-FIFO word.
REQ-009 SHALL have port dout_valid, output, 1: FIFO not empty.
REQ-010 SHALL have port dout_ready, input, 1: consumer accepts dout.
REQ-011 SHALL have port level, output, clog2(DEPTH)+1: FIFO occupancy in words.
REQ-012 SHALL have port overflow, output, 1: sticky flag for a dropped word.
REQ-013 SHALL have port ovf_clr, input, 1: synchronous clear of overflow.

Function
REQ-014 SHALL pack MSB-first: the first captured bit of a word lands in dout[WIDTH-1] and the last in dout[0].
REQ-015 SHALL keep a bit counter 0..WIDTH-1; each capture increments it, and the capture at count WIDTH-1 completes the word and wraps the counter to 0.
REQ-016 SHALL push a completed word on that same edge; the word SHALL appear on dout with dout_valid=1 in the next cycle (1-cycle latency from the final bit's capture edge).
REQ-017 SHALL hold dout on the head word whenever dout_valid=1 (show-ahead); dout SHALL be don't-care while dout_valid=0.
REQ-018 SHALL pop on an edge where dout_valid=1 and dout_ready=1; dout_ready while empty SHALL be ignored.
REQ-019 SHALL handle simultaneous push and pop by leaving level unchanged, including when the FIFO is full, in which case the push is accepted.
REQ-020 SHALL handle a push when full without a pop by dropping the word, setting overflow=1, leaving FIFO contents unchanged, and still wrapping the bit counter to 0.
REQ-021 SHALL, on an edge with both push and pop while empty, take the push only: no pop occurs, level becomes 1, and dout_valid becomes 1 next cycle.
REQ-022 SHALL keep overflow at 1 until ovf_clr=1 or reset; if ovf_clr and a new overflow coincide, overflow SHALL remain 1.
REQ-023 SHALL, on flush=1, clear the bit counter, shift register, FIFO pointers and level on that edge; flush SHALL take priority over capture, push and pop, and SHALL NOT alter overflow.
REQ-024 SHALL advance no state when bit_en=0, so gaps between captured bits are arbitrary.
REQ-025 SHALL keep level consistent with dout_valid: level=0 if and only if dout_valid=0, and level never exceeds DEPTH.
REQ-026 SHALL use FIFO pointers with one extra wrap bit and wrap modulo DEPTH.

Reset
REQ-027 SHALL, while rst=0, immediately force bit counter=0, shift register=0, FIFO empty, level=0, dout_valid=0, dout=0 and overflow=0, independent of clk.
REQ-028 SHALL discard any partial word and all FIFO contents on a reset asserted mid-word or mid-drain; the first capture after release SHALL be bit WIDTH-1 of a new word.
REQ-029 SHALL begin capture on the first rising edge after rst deasserts.

Verification
REQ-030 Basic pack: WIDTH=8, bit_en=1, bits 1,0,1,1,0,0,1,0, dout_ready=0 -> one cycle after the 8th edge, dout=8'hB2, dout_valid=1, level=1.
REQ-031 Gapped enable: the same 8 bits with bit_en toggling 1/0 each cycle -> dout=8'hB2 one cycle after the 8th enabled edge, with no earlier dout_valid.
REQ-032 Overflow: dout_ready=0, push 5 words 8'h01..8'h05 with DEPTH=4 -> level=4, overflow=1, and draining yields 01,02,03,04 then dout_valid=0; ovf_clr then gives overflow=0.
REQ-033 Full with concurrent pop: FIFO full and dout_ready=1 on the edge completing word 8'hAA -> level stays 4, overflow stays 0, and 8'hAA is drained last.
REQ-034 Flush/reset mid-word: capture 5 bits then pulse flush (or rst=0), then bits 0xFF -> dout=8'hFF and the earlier partial word is absent; flush leaves a set overflow at 1.
REQ-035 Continuous stream: random bit_in and random dout_ready over 10k cycles -> the output word sequence equals a reference model's packing of the input, minus exactly the words flagged as dropped.
